fetch_unit: RTL and testbench

Instruction fetch stage of the RISC-V core, directly upstream of decode/control. Owns the PC and issues word requests to instruction memory, which has a fixed one-cycle response latency. Buffers returned {pc, insn} pairs in a 2-entry FIFO and hands them to decode over a valid/ready handshake. Accepts PC redirects from execute, which flush all younger work.

---
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Owns the PC, issues word requests to a fixed one-cycle-latency instruction memory,
// buffers returned {pc, insn} pairs in a 2-entry FIFO and hands them to decode over
// valid/ready. Redirects from execute flush the FIFO and squash in-flight work.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   imem_req_o/addr_o     fetch request and word-aligned address
//   imem_rvalid_i/rdata_i memory response, one cycle after each request
//   insn_valid_o/ready_i  handshake toward decode
//   insn_o, pc_o          head instruction and its PC
//   redirect_i/pc_i       new PC from execute
//   misalign_o            one-cycle pulse after a redirect with target[1:0] != 0
module fetch_unit #(
    parameter int unsigned          AWIDTH   = 32,
    parameter int unsigned          DWIDTH   = 32,
    parameter logic [AWIDTH-1:0]    BASEADDR = AWIDTH'(32'h0100_0000)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_o,
    output logic [AWIDTH-1:0] imem_addr_o,
    input  logic              imem_rvalid_i,
    input  logic [DWIDTH-1:0] imem_rdata_i,
    output logic              insn_valid_o,
    input  logic              insn_ready_i,
    output logic [DWIDTH-1:0] insn_o,
    output logic [AWIDTH-1:0] pc_o,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              misalign_o
);

    logic [AWIDTH-1:0] fetch_pc_q;
    logic [AWIDTH-1:0] inflight_pc_q;
    logic              inflight_q;
    logic              squash_q;
    logic              misalign_q;

    logic [AWIDTH-1:0] fifo_pc_q   [2];
    logic [DWIDTH-1:0] fifo_insn_q [2];
    logic              rd_ptr_q;
    logic              wr_ptr_q;
    logic [1:0]        count_q;

    logic              pop;
    logic              push;
    logic [2:0]        occupancy;

    assign insn_valid_o = (count_q != 2'd0);
    assign insn_o       = fifo_insn_q[rd_ptr_q];
    assign pc_o         = fifo_pc_q[rd_ptr_q];
    assign misalign_o   = misalign_q;

    assign pop  = insn_valid_o & insn_ready_i;
    assign push = inflight_q & imem_rvalid_i & ~squash_q;

    // Slots already claimed once this cycle's pop retires; pop implies count >= 1,
    // so the subtraction cannot underflow.
    assign occupancy   = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    assign imem_req_o  = (occupancy < 3'd2);
    assign imem_addr_o = fetch_pc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q     <= BASEADDR;
            inflight_pc_q  <= '0;
            inflight_q     <= 1'b0;
            squash_q       <= 1'b0;
            misalign_q     <= 1'b0;
            fifo_pc_q[0]   <= '0;
            fifo_pc_q[1]   <= '0;
            fifo_insn_q[0] <= '0;
            fifo_insn_q[1] <= '0;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            count_q        <= 2'd0;
        end else begin
            inflight_q    <= imem_req_o;
            inflight_pc_q <= fetch_pc_q;
            if (redirect_i) begin
                // The request issued this cycle belongs to the old path: drop its response.
                squash_q   <= imem_req_o;
                misalign_q <= (redirect_pc_i[1:0] != 2'b00);
                fetch_pc_q <= {redirect_pc_i[AWIDTH-1:2], 2'b00};
                count_q    <= 2'd0;
                wr_ptr_q   <= rd_ptr_q;
            end else begin
                squash_q   <= 1'b0;
                misalign_q <= 1'b0;
                if (imem_req_o) begin
                    fetch_pc_q <= fetch_pc_q + AWIDTH'(4);
                end
                if (push) begin
                    fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
                    fifo_insn_q[wr_ptr_q] <= imem_rdata_i;
                    wr_ptr_q              <= ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
                count_q <= count_q + 2'(push) - 2'(pop);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] BASE = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        insn_valid_o;
    logic        insn_ready_i = 1'b1;
    logic [31:0] insn_o;
    logic [31:0] pc_o;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        misalign_o;

    int checks = 0;
    int failures = 0;

    fetch_unit #(
        .AWIDTH  (32),
        .DWIDTH  (32),
        .BASEADDR(BASE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .insn_valid_o (insn_valid_o),
        .insn_ready_i (insn_ready_i),
        .insn_o       (insn_o),
        .pc_o         (pc_o),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .misalign_o   (misalign_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    // Instruction memory: answers every request exactly one cycle later.
    always @(posedge clk) begin
        imem_rvalid_i <= imem_req_o;
        imem_rdata_i  <= mem_word(imem_addr_o);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] m_q[$];
    logic [31:0] m_fetch_pc = BASE;
    logic        m_inflight = 1'b0;
    logic [31:0] m_inflight_pc = '0;
    logic        m_squash = 1'b0;
    logic        m_misalign = 1'b0;

    function automatic logic m_pop();
        return (m_q.size() != 0) && insn_ready_i;
    endfunction

    function automatic logic m_req();
        return (m_q.size() + int'(m_inflight) - int'(m_pop())) < 2;
    endfunction

    task automatic model_step();
        logic p;
        logic r;
        p = m_pop();
        r = m_req();
        if (redirect_i) begin
            m_q.delete();
            m_squash   = r;
            m_misalign = (redirect_pc_i[1:0] != 2'b00);
        end else begin
            if (p) void'(m_q.pop_front());
            if (m_inflight && imem_rvalid_i && !m_squash)
                m_q.push_back({m_inflight_pc, mem_word(m_inflight_pc)});
            m_squash   = 1'b0;
            m_misalign = 1'b0;
        end
        m_inflight    = r;
        m_inflight_pc = m_fetch_pc;
        if (redirect_i) m_fetch_pc = redirect_pc_i & ~32'h3;
        else if (r)     m_fetch_pc = m_fetch_pc + 32'd4;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_fetch_pc = BASE;
            m_inflight = 1'b0;
            m_inflight_pc = '0;
            m_squash = 1'b0;
            m_misalign = 1'b0;
        end else begin
            model_step();
        end
    end

    // Per-cycle comparison, after inputs settle and before the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            chk("valid", 32'(insn_valid_o), 32'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                chk("pc", pc_o, m_q[0][63:32]);
                chk("insn", insn_o, m_q[0][31:0]);
            end
            chk("req", 32'(imem_req_o), 32'(m_req()));
            chk("addr", imem_addr_o, m_fetch_pc);
            chk("misalign", 32'(misalign_o), 32'(m_misalign));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input logic rdy, input logic rd, input logic [31:0] rpc);
        @(negedge clk);
        insn_ready_i  = rdy;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        #3;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset        = 1'b1;
        insn_ready_i = 1'b1;
        redirect_i   = 1'b0;
        #3;
        chk("c0_req", 32'(imem_req_o), 32'd1);
        chk("c0_addr", imem_addr_o, BASE);
        chk("c0_valid", 32'(insn_valid_o), 32'd0);
    endtask

    logic [39:0] ready_pat = 40'b1011_0011_1110_0101_1101_1000_1111_0110_1001_1101;

    initial begin
        repeat (2) @(negedge clk);
        #3;
        chk("rst_valid", 32'(insn_valid_o), 32'd0);
        chk("rst_insn", insn_o, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_misalign", 32'(misalign_o), 32'd0);
        chk("rst_req", 32'(imem_req_o), 32'd1);
        chk("rst_addr", imem_addr_o, BASE);

        // Streaming start, then stall with ready low for five cycles.
        release_reset();
        cyc(1, 0, 0);
        chk("c1_addr", imem_addr_o, BASE + 32'h4);
        chk("c1_valid", 32'(insn_valid_o), 32'd0);
        cyc(0, 0, 0);
        chk("c2_valid", 32'(insn_valid_o), 32'd1);
        chk("c2_pc", pc_o, BASE);
        chk("c2_insn", insn_o, BASE ^ 32'h5A5A_5A5A);
        cyc(0, 0, 0);
        chk("c3_req", 32'(imem_req_o), 32'd0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("c6_pc_held", pc_o, BASE);
        chk("c6_req", 32'(imem_req_o), 32'd0);
        cyc(1, 0, 0);
        chk("c7_pc", pc_o, BASE);
        chk("c7_addr", imem_addr_o, BASE + 32'h8);
        cyc(1, 0, 0);
        chk("c8_pc", pc_o, BASE + 32'h4);
        cyc(1, 0, 0);
        chk("c9_pc", pc_o, BASE + 32'h8);

        // Fill the FIFO, then redirect while a request issues.
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("c11_req", 32'(imem_req_o), 32'd0);
        cyc(1, 1, BASE + 32'h100);
        chk("c12_pc", pc_o, BASE + 32'hC);
        chk("c12_addr", imem_addr_o, BASE + 32'h14);
        cyc(1, 0, 0);
        chk("c13_valid", 32'(insn_valid_o), 32'd0);
        chk("c13_addr", imem_addr_o, BASE + 32'h100);
        cyc(1, 0, 0);
        chk("c14_valid", 32'(insn_valid_o), 32'd0);
        cyc(1, 0, 0);
        chk("c15_pc", pc_o, BASE + 32'h100);

        // Misaligned redirect.
        cyc(1, 1, BASE + 32'h102);
        chk("c16_misalign", 32'(misalign_o), 32'd0);
        cyc(1, 0, 0);
        chk("c17_misalign", 32'(misalign_o), 32'd1);
        chk("c17_addr", imem_addr_o, BASE + 32'h100);
        cyc(1, 0, 0);
        chk("c18_misalign", 32'(misalign_o), 32'd0);
        cyc(1, 0, 0);
        chk("c19_pc", pc_o, BASE + 32'h100);

        // Back-to-back redirects.
        cyc(1, 1, BASE + 32'h200);
        cyc(1, 1, BASE + 32'h300);
        chk("c21_addr", imem_addr_o, BASE + 32'h200);
        cyc(1, 0, 0);
        chk("c22_addr", imem_addr_o, BASE + 32'h300);
        chk("c22_valid", 32'(insn_valid_o), 32'd0);
        cyc(1, 0, 0);
        chk("c23_valid", 32'(insn_valid_o), 32'd0);
        cyc(1, 0, 0);
        chk("c24_pc", pc_o, BASE + 32'h300);
        cyc(1, 0, 0);
        chk("c25_pc", pc_o, BASE + 32'h304);

        // Reset mid-operation with the FIFO full and a request issuing.
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("c27_pc", pc_o, BASE + 32'h308);
        chk("c27_addr", imem_addr_o, BASE + 32'h310);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(insn_valid_o), 32'd0);
        chk("mid_rst_pc", pc_o, 32'd0);
        chk("mid_rst_insn", insn_o, 32'd0);
        chk("mid_rst_addr", imem_addr_o, BASE);
        repeat (2) @(negedge clk);
        release_reset();
        cyc(1, 0, 0);
        chk("r1_valid", 32'(insn_valid_o), 32'd0);
        cyc(1, 0, 0);
        chk("r2_pc", pc_o, BASE);
        cyc(1, 0, 0);
        chk("r3_pc", pc_o, BASE + 32'h4);

        // Irregular ready pattern with one mid-stream redirect; model checks every cycle.
        for (int i = 0; i < 40; i++) begin
            cyc(ready_pat[i], (i == 17), BASE + 32'h40);
        end
        cyc(1, 0, 0);
        repeat (4) cyc(1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
